// File: rtl/sprite_blitter_if.sv
// Bus bundle for sprite_blitter: control handshake, sprite ROM read port and framebuffer write port.
// The blitter uses the slave modport; game logic / ROM / framebuffer side uses master.
interface sprite_blitter_if #(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4
);
  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);

  logic          start;
  logic [7:0]    x;
  logic [6:0]    y;
  logic          busy;
  logic          done;
  logic [XW-1:0] rom_x;
  logic [YW-1:0] rom_y;
  logic [2:0]    rom_dout;
  logic [7:0]    fb_x;
  logic [6:0]    fb_y;
  logic [2:0]    fb_color;
  logic          fb_we;

  modport master (
    output start, x, y, rom_dout,
    input  busy, done, rom_x, rom_y, fb_x, fb_y, fb_color, fb_we
  );

  modport slave (
    input  start, x, y, rom_dout,
    output busy, done, rom_x, rom_y, fb_x, fb_y, fb_color, fb_we
  );
endinterface

// File: rtl/sprite_blitter.sv
// Copies one SPRITE_W x SPRITE_H sprite from ROM into the 160x120 framebuffer at a latched (x,y).
// Optional macro TRANSPARENT_EN: ROM colour 0 is treated as transparent and not written.
module sprite_blitter #(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int ROM_LAT  = 1
) (
  input logic             VGA_CLK,
  input logic             resetn,
  sprite_blitter_if.slave bus
);
  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [1:0]         drain_cnt;
  logic               last_addr;
  logic [7:0]         x_lat;
  logic [6:0]         y_lat;
  logic [XW-1:0]      sx_p1 [ROM_LAT];
  logic [YW-1:0]      sy_p1 [ROM_LAT];
  logic [ROM_LAT-1:0] vld_p1;
  logic [8:0]         col_p1;
  logic [7:0]         row_p1;
  logic               opaque_p1;
  logic               wr_p1;

  function automatic logic [8:0] col_sum(input logic [7:0] base, input logic [XW-1:0] off);
    return {1'b0, base} + 9'(off);
  endfunction

  function automatic logic [7:0] row_sum(input logic [6:0] base, input logic [YW-1:0] off);
    return {1'b0, base} + 8'(off);
  endfunction

  function automatic logic on_screen(input logic [8:0] col, input logic [7:0] row);
    return (col < 9'(SCREEN_W)) && (row < 8'(SCREEN_H));
  endfunction

  assign last_addr = (bus.rom_x == XW'(SPRITE_W - 1)) && (bus.rom_y == YW'(SPRITE_H - 1));

  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // DRAIN covers the ROM latency plus the final write slot
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = READ;
      READ:    if (last_addr) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == 2'(ROM_LAT)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: address issue and control outputs
  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      drain_cnt <= '0;
      bus.rom_x <= '0;
      bus.rom_y <= '0;
      vld_p1    <= '0;
    end else begin
      bus.busy  <= (state_nx != IDLE);
      bus.done  <= (state_nx == DONE);
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (state == IDLE)
        {bus.rom_y, bus.rom_x} <= '0;
      else if (state == READ)
        {bus.rom_y, bus.rom_x} <= {bus.rom_y, bus.rom_x} + 1'b1;
      vld_p1[0] <= (state == READ);
      for (int i = 1; i < ROM_LAT; i++) vld_p1[i] <= vld_p1[i-1];
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (state == IDLE && bus.start) begin
      x_lat <= bus.x;
      y_lat <= bus.y;
    end
    sx_p1[0] <= bus.rom_x;
    sy_p1[0] <= bus.rom_y;
    for (int i = 1; i < ROM_LAT; i++) begin
      sx_p1[i] <= sx_p1[i-1];
      sy_p1[i] <= sy_p1[i-1];
    end
  end

  // Stage p1: ROM data aligned with its delayed sprite coordinates
  assign col_p1 = col_sum(x_lat, sx_p1[ROM_LAT-1]);
  assign row_p1 = row_sum(y_lat, sy_p1[ROM_LAT-1]);

`ifdef TRANSPARENT_EN
  assign opaque_p1 = (bus.rom_dout != 3'b000);
`else
  assign opaque_p1 = 1'b1;
`endif

  assign wr_p1 = vld_p1[ROM_LAT-1] && on_screen(col_p1, row_p1) && opaque_p1;

  // Stage p2: framebuffer write port
  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      bus.fb_we    <= 1'b0;
      bus.fb_x     <= '0;
      bus.fb_y     <= '0;
      bus.fb_color <= '0;
    end else begin
      bus.fb_we <= wr_p1;
      if (vld_p1[ROM_LAT-1]) begin
        bus.fb_x     <= col_p1[7:0];
        bus.fb_y     <= row_p1[6:0];
        bus.fb_color <= bus.rom_dout;
      end
    end
  end
endmodule
